// File: rtl/key_schedule_seq_if.sv
// key_schedule_seq_if: start/mode/key request and ready/valid schedule-word stream
interface key_schedule_seq_if #(parameter int MAX_NK = 8);
  logic                  start;
  logic [1:0]            mode;
  logic [32*MAX_NK-1:0]  key;
  logic                  busy;
  logic                  w_valid;
  logic                  w_ready;
  logic [31:0]           w_data;
  logic [5:0]            w_idx;
  logic                  w_last;
  logic                  err;
  modport master (output start, mode, key, w_ready, input busy, w_valid, w_data, w_idx, w_last, err);
  modport slave  (input start, mode, key, w_ready, output busy, w_valid, w_data, w_idx, w_last, err);
endinterface

// File: rtl/key_schedule_seq.sv
// key_schedule_seq: AES-128/192/256 key expansion, one schedule word per handshake
module key_schedule_seq #(parameter int MAX_NK = 8) (
  input logic clk,
  input logic rst_n,
  key_schedule_seq_if.slave ks
);
  typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction
  state_t      state_q, state_d;
  logic [31:0] win_q [MAX_NK];
  logic [31:0] kw [MAX_NK];
  logic [31:0] data_q, word_d, rot, temp;
  logic [5:0]  idx_q, lidx_q, lidx_d;
  logic [2:0]  top_q, top_d, mod_q, mod_n;
  logic [7:0]  rcon_q;
  logic        valid_q, last_q, err_q, acc, go, gen;
  assign ks.busy    = state_q == EMIT;
  assign ks.w_valid = valid_q;
  assign ks.w_data  = data_q;
  assign ks.w_idx   = idx_q;
  assign ks.w_last  = last_q;
  assign ks.err     = err_q;
  // win_q[0] is w[i-1]; window position top_q-1 becomes w[i+1-Nk] once the current word shifts in
  always_comb begin
    for (int m = 0; m < MAX_NK; m++) kw[m] = ks.key[32*(MAX_NK-m)-1 -: 32];
    acc     = valid_q && ks.w_ready;
    go      = state_q == IDLE && ks.start && ks.mode != 2'b11;
    top_d   = ks.mode == 2'b00 ? 3'd3 : ks.mode == 2'b01 ? 3'd5 : 3'd7;
    lidx_d  = ks.mode == 2'b00 ? 6'd43 : ks.mode == 2'b01 ? 6'd51 : 6'd59;
    mod_n   = mod_q == top_q ? 3'd0 : mod_q + 3'd1;
    gen     = idx_q >= {3'b000, top_q};
    rot     = mod_n == 3'd0 ? {data_q[23:0], data_q[31:24]} : data_q;
    temp    = !gen ? 32'h0 : mod_n == 3'd0 ? sub_word(rot) ^ {rcon_q, 24'h0} :
              (top_q == 3'd7 && mod_n == 3'd4) ? sub_word(rot) : data_q;
    word_d  = win_q[top_q - 3'd1] ^ temp;
    state_d = go ? EMIT : (state_q == EMIT && acc && last_q) ? FIN : state_q == FIN ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int j = 0; j < MAX_NK; j++) win_q[j] <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      lidx_q  <= '0;
      top_q   <= '0;
      mod_q   <= '0;
      rcon_q  <= 8'h01;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= state_q == IDLE && ks.start && ks.mode == 2'b11;
      if (go) begin
        top_q  <= top_d;
        lidx_q <= lidx_d;
        rcon_q <= 8'h01;
        for (int j = 0; j < MAX_NK; j++) win_q[j] <= kw[top_d - 3'(j)];
      end else if (state_q == EMIT && !valid_q) begin
        data_q  <= win_q[top_q];
        valid_q <= 1'b1;
        idx_q   <= '0;
        mod_q   <= '0;
        last_q  <= 1'b0;
      end else if (acc) begin
        win_q[0] <= data_q;
        for (int j = 1; j < MAX_NK; j++) win_q[j] <= win_q[j-1];
        valid_q <= !last_q;
        last_q  <= !last_q && (idx_q + 6'd1 == lidx_q);
        if (!last_q) begin
          data_q <= word_d;
          idx_q  <= idx_q + 6'd1;
          mod_q  <= mod_n;
        end
        if (gen && mod_n == 3'd0) rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      end
    end
  end
endmodule

// File: doc/key_schedule_seq.md
KEY_SCHEDULE_SEQ -- requirements
Module: key_schedule_seq

Interface
REQ-001 Parameter MAX_NK, default 8, maximum supported key length in 32-bit words; the block SHALL accept modes up to AES-256.
REQ-002 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request to expand key; sampled only in IDLE.
REQ-005 mode  in  2  key size: 00 = AES-128 (Nk=4, Nr=10), 01 = AES-192 (Nk=6, Nr=12), 10 = AES-256 (Nk=8, Nr=14), 11 = reserved; captured with start.
REQ-006 key  in  32*MAX_NK  cipher key, left-justified, captured with start. key[255:224] is w[0]; unused low words are ignored.
REQ-007 busy  out  1  high from the cycle after start is accepted until the last word is accepted.
REQ-008 w_valid  out  1  w_data/w_idx hold a valid schedule word.
REQ-009 w_ready  in  1  consumer accepts the word when w_valid && w_ready.
REQ-010 w_data  out  32  schedule word w[i], FIPS-197 byte order, MSB = first byte.
REQ-011 w_idx  out  6  index i of w_data, 0..4*Nr+3.
REQ-012 w_last  out  1  high with the final word, i = 4*Nr+3 (43/51/59).
REQ-013 err  out  1  one-cycle pulse when start arrives with mode = 11.

Function
REQ-014 The FSM SHALL have states IDLE, EMIT, and FIN.
- IDLE -> EMIT on start with a legal mode.
- EMIT -> FIN when the word with w_last is accepted.
- FIN -> IDLE unconditionally after one cycle.
REQ-015 In IDLE, start with mode = 11 SHALL pulse err the next cycle and SHALL stay in IDLE with no words emitted.
REQ-016 Latency: if start is accepted at edge N, w_valid with w_idx = 0 SHALL be high after edge N+1.
REQ-017 Words i < Nk SHALL equal the captured key words. Each word i >= Nk SHALL equal w[i-Nk] XOR temp, where temp is chosen by i mod Nk:
- i mod Nk = 0: temp = SubWord(RotWord(w[i-1])) XOR Rcon[i/Nk].
- Nk = 8 and i mod 8 = 4: temp = SubWord(w[i-1]).
- otherwise: temp = w[i-1].
REQ-018 Rcon SHALL follow the sequence 01,02,04,08,10,20,40,80,1b,36 in the top byte. It SHALL be generated by GF(2^8) doubling, with no lookup table.
REQ-019 SubWord SHALL apply the FIPS-197 S-box to 4 bytes combinationally within one cycle.
REQ-020 History SHALL be kept in a MAX_NK-word shift window. A word SHALL enter the window only on handshake acceptance.
REQ-021 While w_valid && !w_ready, w_data, w_idx and w_last SHALL hold stable and generation SHALL stall.
REQ-022 With w_ready held high, one word SHALL be accepted per cycle: 44/52/60 consecutive cycles for mode 00/01/10.
REQ-023 w_valid SHALL drop the cycle after the w_last word is accepted. busy SHALL be low in FIN and IDLE.
REQ-024 start during EMIT or FIN SHALL be ignored, and key/mode changes during EMIT SHALL NOT affect output.
REQ-025 The i/Nk and i mod Nk terms SHALL come from counters. No divider is allowed.

Reset
REQ-026 rst_n low SHALL immediately force:
- state to IDLE;
- busy, w_valid, w_last and err to 0;
- w_data to 0 and w_idx to 0;
- the Rcon register to 01.
REQ-027 Reset asserted mid-expansion SHALL abort it. After release, no stale word SHALL be presented until a new start is accepted.

Verification
REQ-028 AES-128 (FIPS-197 A.1), key 2b7e1516 28aed2a6 abf71588 09cf4f3c, w_ready = 1:
- w[4] = a0fafe17.
- w[43] = b6630ca6, with w_last.
- 44 consecutive valid cycles.
REQ-029 AES-192 (A.2), key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
- w[6] = fe0c91f7.
- w[51] = 01002202, with w_last.
REQ-030 AES-256 (A.3), key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
- w[8] = 9ba35411.
- w[59] = 706c631e.
REQ-031 Backpressure: run the A.1 vector with random w_ready (about 50%).
- Output SHALL be identical to REQ-028.
- w_data SHALL be stable across every stalled cycle.
- start pulses during busy SHALL be ignored.
REQ-032 mode = 11 with start -> err pulses once, busy and w_valid stay 0. A following legal start SHALL run normally.
REQ-033 Assert rst_n low at w_idx = 20 during an AES-256 run:
- All outputs SHALL be 0 immediately.
- After release and a new AES-128 start, the run SHALL reproduce REQ-028 exactly.
